elevator_ctrl: RTL and testbench

Three-floor elevator controller that sequences the 7-segment floor/direction display decoder. Latches call requests for floors 0–2, schedules travel with a collective (keep-direction) policy, times travel and door-open intervals, and drives the 3-bit display code `{i2,i1,i0}` that the decoder turns into the floor number, up/down animation or stop pattern. Sits between the call-button synchronisers and the display decoder.

---
 rtl/elevator_ctrl.sv | 156 +++++++++++++++
 tb/tb_elevator_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Three-floor collective elevator controller feeding the floor/direction display decoder.
// Latency: call visible on pending next cycle; outputs are Moore, one cycle after decisions.
// Backpressure: none; optional emergency stop via ELEV_ESTOP_EN (adds i_estop and ESTOP state).
module elevator_ctrl #(
   parameter int TRAVEL_CYCLES = 50_000_000,
   parameter int DOOR_CYCLES   = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef ELEV_ESTOP_EN
   input  logic       i_estop,
`endif
   input  logic [2:0] i_call,
   output logic [2:0] o_disp_code,
   output logic [1:0] o_floor,
   output logic       o_door_open,
   output logic       o_moving,
   output logic       o_dir_up,
   output logic [2:0] o_pending
);

   localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);
   localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES);
   localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES);

`ifdef ELEV_ESTOP_EN
   typedef enum logic [2:0] {ST_IDLE, ST_DOOR, ST_UP, ST_DN, ST_ESTOP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_DOOR, ST_UP, ST_DN} state_t;
`endif

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_floor, w_floor_nxt, w_next_floor;
   logic          r_dir_up, w_dir_nxt;
   logic [2:0]    r_pending, w_pending_nxt;
   logic [TW-1:0] r_timer, w_timer_nxt;
   logic [2:0]    w_req, w_here, w_next_here;
   logic          w_up_req, w_dn_req, w_expire;

   assign w_req       = r_pending | i_call;
   assign w_here      = 3'b001 << r_floor;
   assign w_expire    = (r_timer == TW'(1));
   assign w_next_floor = (r_state == ST_UP) ? ((r_floor == 2'd2) ? r_floor : r_floor + 2'd1)
                                            : ((r_floor == 2'd0) ? r_floor : r_floor - 2'd1);
   assign w_next_here = 3'b001 << w_next_floor;

   always_comb begin
      w_up_req = 1'b0;
      w_dn_req = 1'b0;
      case (r_floor)
         2'd0:    w_up_req = |w_req[2:1];
         2'd1:    begin
                     w_up_req = w_req[2];
                     w_dn_req = w_req[0];
                  end
         default: w_dn_req = |w_req[1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_floor   <= 2'd0;
         r_dir_up  <= 1'b1;
         r_pending <= 3'b000;
         r_timer   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_floor   <= w_floor_nxt;
         r_dir_up  <= w_dir_nxt;
         r_pending <= w_pending_nxt;
         r_timer   <= w_timer_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_floor_nxt   = r_floor;
      w_dir_nxt     = r_dir_up;
      w_pending_nxt = w_req;
      w_timer_nxt   = (r_timer != '0) ? r_timer - TW'(1) : r_timer;
      case (r_state)
         ST_IDLE: begin
            if (|(w_req & w_here)) begin
               w_state_nxt   = ST_DOOR;
               w_timer_nxt   = DOOR_LD;
               w_pending_nxt = w_req & ~w_here;
            end else if (w_up_req && (r_dir_up || !w_dn_req)) begin
               w_state_nxt = ST_UP;
               w_dir_nxt   = 1'b1;
               w_timer_nxt = TRAVEL_LD;
            end else if (w_dn_req) begin
               w_state_nxt = ST_DN;
               w_dir_nxt   = 1'b0;
               w_timer_nxt = TRAVEL_LD;
            end
         end
         ST_UP, ST_DN: begin
            // Arrival: stop only if someone wants this floor, else keep travelling.
            if (w_expire) begin
               w_floor_nxt = w_next_floor;
               w_timer_nxt = TRAVEL_LD;
               if (|(w_req & w_next_here)) begin
                  w_state_nxt   = ST_DOOR;
                  w_timer_nxt   = DOOR_LD;
                  w_pending_nxt = w_req & ~w_next_here;
               end
            end
         end
         ST_DOOR: begin
            w_pending_nxt = r_pending | (i_call & ~w_here);
            if (|(i_call & w_here)) begin
               w_timer_nxt = DOOR_LD;
            end else if (w_expire) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
            end
         end
`ifdef ELEV_ESTOP_EN
         ST_ESTOP: begin
            w_state_nxt   = ST_IDLE;
            w_pending_nxt = 3'b000;
            w_timer_nxt   = '0;
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
`ifdef ELEV_ESTOP_EN
      if (i_estop) begin
         w_state_nxt   = ST_ESTOP;
         w_floor_nxt   = r_floor;
         w_dir_nxt     = r_dir_up;
         w_pending_nxt = 3'b000;
         w_timer_nxt   = '0;
      end
`endif
   end

   always_comb begin
      o_floor     = r_floor;
      o_dir_up    = r_dir_up;
      o_pending   = r_pending;
      o_door_open = (r_state == ST_DOOR);
      o_moving    = (r_state == ST_UP) || (r_state == ST_DN);
      case (r_state)
         ST_UP:    o_disp_code = 3'b011;
         ST_DN:    o_disp_code = 3'b100;
`ifdef ELEV_ESTOP_EN
         ST_ESTOP: o_disp_code = 3'b111;
`endif
         default:  o_disp_code = {1'b0, r_floor};
      endcase
   end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: an event/deadline reference model predicts every cycle's outputs.
module tb_elevator_ctrl;

   localparam int TRAVEL = 4;
   localparam int DOOR   = 3;

   typedef struct packed {
      logic [2:0] disp;
      logic [1:0] flr;
      logic       door;
      logic       mov;
      logic       dir;
      logic [2:0] pend;
   } obs_t;

   typedef enum int {M_IDLE, M_DOOR, M_UP, M_DN, M_ESTOP} mode_t;

   typedef struct {
      string name;
      int    got;
      int    exp;
   } dchk_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] call  = 3'b000;
`ifdef ELEV_ESTOP_EN
   logic       estop = 1'b0;
`endif
   logic [2:0] disp_code, pending;
   logic [1:0] floor;
   logic       door_open, moving, dir_up;

   obs_t  q[$];
   dchk_t dq[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   // reference model state: absolute-deadline based
   mode_t      m_mode     = M_IDLE;
   int         m_floor    = 0;
   logic       m_dir      = 1'b1;
   logic [2:0] m_pend     = 3'b000;
   int         m_deadline = 0;
   int         cyc        = 0;
   bit         prev_rst   = 1'b1;

   obs_t  mon_exp, mon_got;
   dchk_t mon_d;

   elevator_ctrl #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef ELEV_ESTOP_EN
      .i_estop     (estop),
`endif
      .i_call      (call),
      .o_disp_code (disp_code),
      .o_floor     (floor),
      .o_door_open (door_open),
      .o_moving    (moving),
      .o_dir_up    (dir_up),
      .o_pending   (pending)
   );

   initial forever #5 clk = ~clk;

   function automatic obs_t expect_obs();
      obs_t o;
      o.flr  = 2'(m_floor);
      o.door = (m_mode == M_DOOR);
      o.mov  = (m_mode == M_UP) || (m_mode == M_DN);
      o.dir  = m_dir;
      o.pend = m_pend;
      case (m_mode)
         M_UP:    o.disp = 3'd3;
         M_DN:    o.disp = 3'd4;
         M_ESTOP: o.disp = 3'd7;
         default: o.disp = 3'(m_floor);
      endcase
      return o;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_floor = 0;
      m_dir   = 1'b1;
      m_pend  = 3'b000;
   endtask

   task automatic open_door();
      m_mode           = M_DOOR;
      m_pend[m_floor]  = 1'b0;
      m_deadline       = cyc + DOOR;
   endtask

   task automatic model_step();
      logic [2:0] req;
      bit above, below;
      cyc++;
      req = m_pend | call;
`ifdef ELEV_ESTOP_EN
      if (estop) begin
         m_mode = M_ESTOP;
         m_pend = 3'b000;
         return;
      end
`endif
      case (m_mode)
         M_IDLE: begin
            m_pend = req;
            if (req[m_floor]) open_door();
            else begin
               above = 0;
               below = 0;
               for (int k = 0; k < 3; k++) begin
                  if (req[k] && k > m_floor) above = 1;
                  if (req[k] && k < m_floor) below = 1;
               end
               if (above && (m_dir || !below)) begin
                  m_mode = M_UP; m_dir = 1'b1; m_deadline = cyc + TRAVEL;
               end else if (below) begin
                  m_mode = M_DN; m_dir = 1'b0; m_deadline = cyc + TRAVEL;
               end
            end
         end
         M_UP, M_DN: begin
            m_pend = req;
            if (cyc == m_deadline) begin
               m_floor += (m_mode == M_UP) ? 1 : -1;
               if (req[m_floor]) open_door();
               else m_deadline = cyc + TRAVEL;
            end
         end
         M_DOOR: begin
            if (call[m_floor]) begin
               m_pend          = m_pend | call;
               m_pend[m_floor] = 1'b0;
               m_deadline      = cyc + DOOR;
            end else begin
               m_pend = req;
               if (cyc == m_deadline) m_mode = M_IDLE;
            end
         end
`ifdef ELEV_ESTOP_EN
         M_ESTOP: m_mode = M_IDLE;
`endif
         default: ;
      endcase
   endtask

   // expectation producer: one entry per clock; async reset overrides the pending entry
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         model_reset();
         if (!prev_rst) q.push_back(expect_obs());
         else if (q.size() > 0) q[q.size()-1] = expect_obs();
         prev_rst = 1'b0;
      end else begin
         prev_rst = 1'b1;
         model_step();
         q.push_back(expect_obs());
      end
   end

   // monitor: compares on the falling edge
   initial forever begin
      @(negedge clk);
      if (q.size() > 0) begin
         mon_exp = q.pop_front();
         mon_got = {disp_code, floor, door_open, moving, dir_up, pending};
         n_tests++;
         if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL outputs @%0t: got disp=%b floor=%0d door=%b moving=%b dir_up=%b pending=%b, expected disp=%b floor=%0d door=%b moving=%b dir_up=%b pending=%b",
                     $time, mon_got.disp, mon_got.flr, mon_got.door, mon_got.mov, mon_got.dir, mon_got.pend,
                     mon_exp.disp, mon_exp.flr, mon_exp.door, mon_exp.mov, mon_exp.dir, mon_exp.pend);
         end
      end
      while (dq.size() > 0) begin
         mon_d = dq.pop_front();
         n_tests++;
         if (mon_d.got != mon_d.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", mon_d.name, mon_d.got, mon_d.exp);
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic [2:0] c);
      call = c;
      cyc_wait(1);
      call = 3'b000;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not terminate");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int found, door_len;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      cyc_wait(1);

      // call at the current floor
      pulse(3'b001);
      cyc_wait(8);
      // 0 -> 2 non-stop, then back to 0
      pulse(3'b100);
      cyc_wait(14);
      pulse(3'b001);
      cyc_wait(14);
      // intermediate stop at floor 1 while heading to 2
      pulse(3'b100);
      cyc_wait(1);
      pulse(3'b010);
      cyc_wait(20);
      pulse(3'b001);
      cyc_wait(14);

      // door restart at floor 2
      pulse(3'b100);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (door_open && floor == 2'd2) begin
            found = 1;
            break;
         end
      end
      #1;
      dq.push_back('{"door_reached_floor2", found, 1});
      call = 3'b100;
      cyc_wait(1);
      call = 3'b000;
      door_len = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (door_open) door_len++;
         else break;
      end
      dq.push_back('{"door_restart_length", door_len, 4});

      // reset while travelling down
      cyc_wait(3);
      pulse(3'b001);
      cyc_wait(2);
      rst_n = 1'b0;
      cyc_wait(2);
      rst_n = 1'b1;
      cyc_wait(1);

      // floor 1 with dir_up=1, requests both ways
      pulse(3'b010);
      cyc_wait(10);
      pulse(3'b101);
      cyc_wait(30);

`ifdef ELEV_ESTOP_EN
      pulse(3'b100);
      cyc_wait(1);
      estop = 1'b1;
      cyc_wait(3);
      estop = 1'b0;
      cyc_wait(4);
`endif

      for (int i = 0; i < 1500; i++) begin
         call = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
`ifdef ELEV_ESTOP_EN
         estop = ($urandom_range(0, 63) == 0);
`endif
         cyc_wait(1);
      end
      call = 3'b000;
`ifdef ELEV_ESTOP_EN
      estop = 1'b0;
`endif
      cyc_wait(40);
      cyc_wait(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
